// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and state encoding for the memory bus arbiter.
// Consumed by mem_bus_arbiter and its watchdog (ARB_TIMEOUT_EN builds).
package mem_bus_arbiter_pkg;

   localparam logic        RstEnable         = 1'b1;
   localparam int          RegBus            = 32;
   localparam logic [RegBus-1:0] ZeroWord    = '0;
   localparam logic [3:0]  SelAll            = 4'b1111;
   localparam int unsigned ArbTimeoutDefault = 255;

   typedef enum logic [1:0] {
      ArbIdle   = 2'd0,
      ArbIfCyc  = 2'd1,
      ArbMemCyc = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// arb_watchdog: counts busy cycles without bus_ack and flags expiry.
// Only present when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_watchdog
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = ArbTimeoutDefault
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expire
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         cnt <= 8'd0;
      end else if (clear) begin
         cnt <= 8'd0;
      end else if (tick) begin
         cnt <= cnt + 8'd1;
      end
   end

   // Fires on the LIMIT-th consecutive unanswered busy cycle.
   assign expire = tick && (cnt == 8'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises fetch and data requests onto one memory bus.
// Define ARB_TIMEOUT_EN to abort bus cycles that see no bus_ack in time.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = ArbTimeoutDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              if_req,
   input  logic [RegBus-1:0] if_addr,
   output logic [RegBus-1:0] if_rdata,
   output logic              if_ack,
   output logic              if_stallreq,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [3:0]        mem_sel,
   input  logic [RegBus-1:0] mem_addr,
   input  logic [RegBus-1:0] mem_wdata,
   output logic [RegBus-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              mem_stallreq,
   output logic              bus_cyc,
   output logic              bus_stb,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [RegBus-1:0] bus_addr,
   output logic [RegBus-1:0] bus_wdata,
   input  logic [RegBus-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              bus_timeout
);

   arb_state_e state, state_nxt;
   logic discard;
   logic busy, if_elig, mem_elig, grant_if, grant_mem;
   logic expire, done, drop_result;

   // A port whose ack is pulsing still shows its old request; keep it out.
   always_comb begin
      busy        = (state != ArbIdle);
      if_elig     = if_req && !if_ack;
      mem_elig    = mem_req && !mem_ack;
      grant_mem   = !busy && !flush && mem_elig;
      grant_if    = !busy && !flush && !mem_elig && if_elig;
      done        = busy && (bus_ack || expire);
      drop_result = discard || flush;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ArbIdle: begin
            if (grant_mem)     state_nxt = ArbMemCyc;
            else if (grant_if) state_nxt = ArbIfCyc;
         end
         ArbIfCyc, ArbMemCyc: begin
            if (done) state_nxt = ArbIdle;
         end
         default: state_nxt = ArbIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state     <= ArbIdle;
         discard   <= 1'b0;
         if_ack    <= 1'b0;
         if_rdata  <= ZeroWord;
         mem_ack   <= 1'b0;
         mem_rdata <= ZeroWord;
         bus_cyc   <= 1'b0;
         bus_we    <= 1'b0;
         bus_sel   <= 4'b0000;
         bus_addr  <= ZeroWord;
         bus_wdata <= ZeroWord;
      end else begin
         state   <= state_nxt;
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         if (grant_mem) begin
            bus_cyc   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
         end else if (grant_if) begin
            bus_cyc   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= SelAll;
            bus_addr  <= if_addr;
            bus_wdata <= ZeroWord;
         end
         if (busy && flush) discard <= 1'b1;
         if (done) begin
            bus_cyc <= 1'b0;
            discard <= 1'b0;
            if (!drop_result) begin
               // An aborted cycle (expire without bus_ack) returns ZeroWord.
               if (state == ArbIfCyc) begin
                  if_ack   <= 1'b1;
                  if_rdata <= bus_ack ? bus_rdata : ZeroWord;
               end else begin
                  mem_ack   <= 1'b1;
                  mem_rdata <= (bus_ack && !bus_we) ? bus_rdata : ZeroWord;
               end
            end
         end
      end
   end

   assign bus_stb      = bus_cyc;
   assign if_stallreq  = if_req && !if_ack;
   assign mem_stallreq = mem_req && !mem_ack;

`ifdef ARB_TIMEOUT_EN
   logic timeout_q;

   arb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (grant_if || grant_mem),
      .tick   (busy && !bus_ack),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) timeout_q <= 1'b0;
      else                  timeout_q <= expire;
   end

   assign bus_timeout = timeout_q;
`else
   logic [7:0] unused_timeout;
   assign unused_timeout = 8'(TIMEOUT_CYCLES);
   assign expire         = 1'b0;
   assign bus_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level scoreboard.
module tb_mem_bus_arbiter;

   localparam int W = 32;
`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TO       = 4;
   localparam int          EXP_TO_N = 1;
`else
   localparam int unsigned TO       = 255;
   localparam int          EXP_TO_N = 0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         flush = 1'b0;
   logic         if_req = 1'b0;
   logic [W-1:0] if_addr = '0;
   logic [W-1:0] if_rdata;
   logic         if_ack, if_stallreq;
   logic         mem_req = 1'b0;
   logic         mem_we = 1'b0;
   logic [3:0]   mem_sel = 4'h0;
   logic [W-1:0] mem_addr = '0;
   logic [W-1:0] mem_wdata = '0;
   logic [W-1:0] mem_rdata;
   logic         mem_ack, mem_stallreq;
   logic         bus_cyc, bus_stb, bus_we;
   logic [3:0]   bus_sel;
   logic [W-1:0] bus_addr, bus_wdata;
   logic [W-1:0] bus_rdata = '0;
   logic         bus_ack = 1'b0;
   logic         bus_timeout;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_ack(if_ack), .if_stallreq(if_stallreq),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .mem_stallreq(mem_stallreq),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
      .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_timeout(bus_timeout)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int to_pulses = 0;
   always @(negedge clk) if (bus_timeout === 1'b1) to_pulses++;

   initial begin
      #600000;
      $display("FAIL sim_time_limit: got no finish, expected finish before limit");
      $fatal(1, "time limit");
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] last_if_rdata = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, 32'(act), 32'(exp));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      flush = 1'b0; bus_ack = 1'b0;
      if_req = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = '0; mem_wdata = '0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         is_mem;
      logic         we;
      logic [3:0]   sel;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
      int           wait_n;
      logic [W-1:0] sdata;
      int           exp_ack_cyc;
      logic [W-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   // Request at cycle 0; slave acks after wait_n extra busy cycles.
   task automatic run_vec(input vec_t v);
      int ack_cyc, busy_n;
      logic [W-1:0] rd;
      logic stall_ok, pack, pstall;
      ack_cyc = -1; busy_n = 0; rd = '0; stall_ok = 1'b1;
      if (v.is_mem) begin
         mem_req = 1'b1; mem_we = v.we; mem_sel = v.sel; mem_addr = v.addr; mem_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int c = 0; c < 24 && ack_cyc < 0; c++) begin
         bus_ack = 1'b0;
         if (bus_cyc) begin
            if (busy_n == 0) begin
               check("vec grant cycle", 32'(c), 32'd1);
               check1("vec bus_we", bus_we, v.is_mem ? v.we : 1'b0);
               check("vec bus_sel", 32'(bus_sel), 32'(v.is_mem ? v.sel : 4'hF));
               check("vec bus_addr", bus_addr, v.addr);
               if (v.is_mem && v.we) check("vec bus_wdata", bus_wdata, v.wdata);
            end
            if (busy_n == v.wait_n) begin
               bus_ack = 1'b1; bus_rdata = v.sdata;
            end
            busy_n++;
         end
         #1;
         pack   = v.is_mem ? mem_ack : if_ack;
         pstall = v.is_mem ? mem_stallreq : if_stallreq;
         if (pack) begin
            ack_cyc = c;
            rd = v.is_mem ? mem_rdata : if_rdata;
            if (pstall !== 1'b0) stall_ok = 1'b0;
         end else if (pstall !== 1'b1) stall_ok = 1'b0;
         tick();
      end
      clear_inputs();
      check("vec ack cycle", 32'(ack_cyc), 32'(v.exp_ack_cyc));
      check("vec rdata", rd, v.exp_rdata);
      check1("vec stallreq", stall_ok, 1'b1);
      #1;
      check1("vec no regrant", bus_cyc, 1'b0);
      check1("vec single ack", v.is_mem ? mem_ack : if_ack, 1'b0);
      if (!v.is_mem) last_if_rdata = v.exp_rdata;
      tick();
   endtask

   // ---------------- hand-written sequences ----------------
   task automatic seq_both();
      int g1, g2, ma, ia, n_ma, n_ia, n_rise;
      logic pc, we1, we2;
      logic [W-1:0] a1, a2, wd1, ird, mrd;
      g1 = -1; g2 = -1; ma = -1; ia = -1; n_ma = 0; n_ia = 0; n_rise = 0; pc = 1'b0;
      we1 = 1'b0; we2 = 1'b1; a1 = '0; a2 = '0; wd1 = '0; ird = '0; mrd = '1;
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h2000; mem_wdata = 32'h12345678;
      if_req = 1'b1; if_addr = 32'h100;
      for (int c = 0; c < 12; c++) begin
         bus_ack = 1'b0;
         if (bus_cyc && !pc) begin
            n_rise++;
            if (g1 < 0) begin g1 = c; we1 = bus_we; a1 = bus_addr; wd1 = bus_wdata; end
            else begin g2 = c; we2 = bus_we; a2 = bus_addr; end
         end
         if (bus_cyc) begin bus_ack = 1'b1; bus_rdata = 32'hA5A50001; end
         pc = bus_cyc;
         if (mem_ack) begin n_ma++; ma = c; mrd = mem_rdata; end
         if (if_ack)  begin n_ia++; ia = c; ird = if_rdata; end
         tick();
         if (ma >= 0) mem_req = 1'b0;
         if (ia >= 0) if_req = 1'b0;
      end
      clear_inputs();
      check("both first grant", 32'(g1), 32'd1);
      check1("both first we", we1, 1'b1);
      check("both first addr", a1, 32'h2000);
      check("both first wdata", wd1, 32'h12345678);
      check("both mem_ack cycle", 32'(ma), 32'd2);
      check("both mem_rdata", mrd, 32'h0);
      check("both second grant", 32'(g2), 32'd3);
      check1("both second we", we2, 1'b0);
      check("both second addr", a2, 32'h100);
      check("both if_ack cycle", 32'(ia), 32'd4);
      check("both if_rdata", ird, 32'hA5A50001);
      check("both mem_ack count", 32'(n_ma), 32'd1);
      check("both if_ack count", 32'(n_ia), 32'd1);
      check("both grant count", 32'(n_rise), 32'd2);
      last_if_rdata = 32'hA5A50001;
   endtask

   task automatic seq_flush_busy();
      int n_busy, n_ack;
      logic cyc4, cyc5;
      n_busy = 0; n_ack = 0; cyc4 = 1'b0; cyc5 = 1'b1;
      if_req = 1'b1; if_addr = 32'h300;
      for (int c = 0; c < 10; c++) begin
         bus_ack = 1'b0;
         flush = (c == 1);
         if (c == 2) if_req = 1'b0;
         if (bus_cyc) n_busy++;
         if (c == 4) cyc4 = bus_cyc;
         if (c == 5) cyc5 = bus_cyc;
         if (c == 4 && bus_cyc) begin bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD; end
         if (if_ack || mem_ack) n_ack++;
         tick();
      end
      clear_inputs();
      check("flush busy cycles", 32'(n_busy), 32'd4);
      check1("flush bus held at ack", cyc4, 1'b1);
      check1("flush bus released", cyc5, 1'b0);
      check("flush ack count", 32'(n_ack), 32'd0);
      check("flush if_rdata kept", if_rdata, last_if_rdata);
   endtask

   task automatic seq_flush_idle();
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h2100; flush = 1'b1;
      tick();
      flush = 1'b0;
      check1("flush idle blocks grant", bus_cyc, 1'b0);
      tick();
      check1("flush idle later grant", bus_cyc, 1'b1);
      bus_ack = 1'b1; bus_rdata = 32'h11223344;
      tick();
      bus_ack = 1'b0;
      check1("flush idle mem_ack", mem_ack, 1'b1);
      check("flush idle mem_rdata", mem_rdata, 32'h11223344);
      tick();
      clear_inputs();
      check1("flush idle no regrant", bus_cyc, 1'b0);
      tick();
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic seq_timeout();
      int n_busy, to_c, ack_c, p0;
      logic [W-1:0] rd;
      n_busy = 0; to_c = -1; ack_c = -1; p0 = to_pulses; rd = '1;
      mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h4000;
      for (int c = 0; c < 10; c++) begin
         bus_ack = 1'b0;
         if (bus_cyc) n_busy++;
         if (bus_timeout && to_c < 0) to_c = c;
         if (mem_ack) begin ack_c = c; rd = mem_rdata; end
         tick();
         if (ack_c >= 0) mem_req = 1'b0;
      end
      clear_inputs();
      check("timeout busy cycles", 32'(n_busy), 32'd4);
      check("timeout pulse cycle", 32'(to_c), 32'd5);
      check("timeout mem_ack cycle", 32'(ack_c), 32'd5);
      check("timeout mem_rdata", rd, 32'h0);
      check("timeout pulse count", 32'(to_pulses - p0), 32'd1);
   endtask
`endif

   task automatic seq_reset_mid();
      mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hF; mem_addr = 32'h3000; mem_wdata = 32'hCAFE0001;
      tick();
      check1("rstmid bus_cyc before", bus_cyc, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      check1("rstmid bus_cyc", bus_cyc, 1'b0);
      check1("rstmid bus_stb", bus_stb, 1'b0);
      check1("rstmid bus_we", bus_we, 1'b0);
      check("rstmid bus_addr", bus_addr, 32'h0);
      check1("rstmid mem_ack", mem_ack, 1'b0);
      check1("rstmid if_ack", if_ack, 1'b0);
      check("rstmid if_rdata", if_rdata, 32'h0);
      clear_inputs();
      rst = 1'b0;
      tick();
      last_if_rdata = '0;
   endtask

   // ---------------- randomized traffic ----------------
   task automatic random_phase(input int n_cycles, input int drain);
      logic [W-1:0] if_exp_q[$];
      logic [W-1:0] exp_q[$];
      logic exp_if_now, exp_mem_now, exp_if_nxt, exp_mem_nxt;
      logic prev_cyc, prev_mem_elig, owner_mem, drop_if, drop_mem;
      logic [W-1:0] exp_rd;
      int wait_left, if_age, mem_age, max_age;
      exp_if_now = 1'b0; exp_mem_now = 1'b0; prev_cyc = 1'b0; prev_mem_elig = 1'b0;
      owner_mem = 1'b0; drop_if = 1'b0; drop_mem = 1'b0;
      wait_left = 0; if_age = 0; mem_age = 0; max_age = 0;
      for (int c = 0; c < n_cycles; c++) begin
         check1("rand if_ack", if_ack, exp_if_now);
         check1("rand mem_ack", mem_ack, exp_mem_now);
         if (exp_if_now) begin
            exp_rd = if_exp_q.pop_front();
            check("rand if_rdata", if_rdata, exp_rd);
         end
         if (exp_mem_now) begin
            exp_rd = exp_q.pop_front();
            check("rand mem_rdata", mem_rdata, exp_rd);
         end
         if (drop_if)  begin if_req = 1'b0; if_age = 0; end
         if (drop_mem) begin mem_req = 1'b0; mem_age = 0; end
         if (c < n_cycles - drain) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
               if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!mem_req && $urandom_range(0, 2) == 0) begin
               mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
               mem_sel = 4'($urandom_range(1, 15));
               mem_addr = $urandom & 32'hFFFF_FFFC; mem_wdata = $urandom;
            end
         end
         if (if_req)  if_age++;
         if (mem_req) mem_age++;
         if (if_age > max_age)  max_age = if_age;
         if (mem_age > max_age) max_age = mem_age;
         exp_if_nxt = 1'b0; exp_mem_nxt = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
         if (bus_cyc) begin
            if (!prev_cyc) begin
               // Data port wins whenever it was eligible in the decision cycle.
               owner_mem = prev_mem_elig;
               wait_left = $urandom_range(0, 3);
               if (owner_mem) begin
                  check1("rand mem bus_we", bus_we, mem_we);
                  check("rand mem bus_sel", 32'(bus_sel), 32'(mem_sel));
                  check("rand mem bus_addr", bus_addr, mem_addr);
                  check("rand mem bus_wdata", bus_wdata, mem_wdata);
               end else begin
                  check1("rand if bus_we", bus_we, 1'b0);
                  check("rand if bus_sel", 32'(bus_sel), 32'hF);
                  check("rand if bus_addr", bus_addr, if_addr);
               end
            end
            if (wait_left == 0) begin
               bus_ack = 1'b1;
               if (owner_mem) begin exp_q.push_back(mem_we ? '0 : bus_rdata); exp_mem_nxt = 1'b1; end
               else begin if_exp_q.push_back(bus_rdata); exp_if_nxt = 1'b1; end
            end else wait_left--;
         end else begin
            bus_ack = ($urandom_range(0, 5) == 0);
         end
         #1;
         check1("rand if_stallreq", if_stallreq, if_req && !exp_if_now);
         check1("rand mem_stallreq", mem_stallreq, mem_req && !exp_mem_now);
         prev_mem_elig = mem_req && !exp_mem_now;
         prev_cyc = bus_cyc;
         drop_if = if_ack;
         drop_mem = mem_ack;
         exp_if_now = exp_if_nxt;
         exp_mem_now = exp_mem_nxt;
         tick();
      end
      clear_inputs();
      check("rand if queue drained", 32'(if_exp_q.size()), 32'd0);
      check("rand mem queue drained", 32'(exp_q.size()), 32'd0);
      check1("rand bus idle at end", bus_cyc, 1'b0);
      check1("rand max wait bounded", max_age <= 20, 1'b1);
   endtask

   // ---------------- main ----------------
   initial begin
      vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h100,  32'h0,        1, 32'hDEADBEEF, 3, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 1'b0, 4'hF, 32'h104,  32'h0,        0, 32'h0BADF00D, 2, 32'h0BADF00D};
      vecs[2] = '{1'b1, 1'b0, 4'h3, 32'h2004, 32'h0,        2, 32'hCAFEBABE, 4, 32'hCAFEBABE};
      vecs[3] = '{1'b1, 1'b1, 4'hF, 32'h2000, 32'h12345678, 0, 32'hFFFFFFFF, 2, 32'h0};
      vecs[4] = '{1'b1, 1'b1, 4'h1, 32'h2008, 32'h000000AB, 3, 32'h55555555, 5, 32'h0};
`ifdef ARB_TIMEOUT_EN
      vecs[5] = '{1'b1, 1'b0, 4'hF, 32'h200C, 32'h0,        3, 32'h600DDA7A, 5, 32'h600DDA7A};
`else
      vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h108,  32'h0,        9, 32'h13579BDF, 11, 32'h13579BDF};
`endif

      clear_inputs();
      rst = 1'b1;
      repeat (3) tick();
      check1("reset bus_cyc", bus_cyc, 1'b0);
      check1("reset bus_stb", bus_stb, 1'b0);
      check1("reset bus_we", bus_we, 1'b0);
      check("reset bus_sel", 32'(bus_sel), 32'h0);
      check("reset bus_addr", bus_addr, 32'h0);
      check("reset bus_wdata", bus_wdata, 32'h0);
      check1("reset if_ack", if_ack, 1'b0);
      check1("reset mem_ack", mem_ack, 1'b0);
      check("reset if_rdata", if_rdata, 32'h0);
      check("reset mem_rdata", mem_rdata, 32'h0);
      check1("reset bus_timeout", bus_timeout, 1'b0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);
      seq_both();
      seq_flush_busy();
      seq_flush_idle();
`ifdef ARB_TIMEOUT_EN
      seq_timeout();
`endif
      seq_reset_mid();
      run_vec('{1'b0, 1'b0, 4'hF, 32'h500, 32'h0, 1, 32'h77665544, 3, 32'h77665544});
      random_phase(2000, 40);
      check("timeout pulse total", 32'(to_pulses), 32'(EXP_TO_N));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
